fb_fetch_arbiter: RTL and testbench
===================================

# fb_fetch_arbiter

Schedules the single-port frame memory between display line prefetch and a pixel writer, driven by the video timing counters (`h_count`/`v_count`). At the start of every line it fetches the next visible line into one bank of an external ping-pong line buffer. The display fetch has absolute priority: it preempts the writer at a word boundary. The writer gets every remaining memory cycle.

## Interface
- `H_ACTIVE`, 1280: visible pixels per line
- `H_TOTAL`, 1650: clocks per line
- `V_ACTIVE`, 720: visible lines
- `V_TOTAL`, 750: lines per frame
- `PIX_PER_WORD`, 4: pixels packed per memory word; `LINE_WORDS = H_ACTIVE/PIX_PER_WORD` (320)
- `ADDR_W`, 18: memory word address width
- `DATA_W`, 32: memory data width

Ports:
- `rfr_clk`  in  1  pixel clock; the only clock
- `reset_p`  in  1  reset, synchronous, active-high
- `h_count`  in  12  pixel counter from the timing generator
- `v_count`  in  12  line counter from the timing generator
- `wr_req`  in  1  writer has a word; holds `wr_addr`/`wr_data` stable until `wr_gnt`
- `wr_addr`  in  ADDR_W  writer word address
- `wr_data`  in  DATA_W  writer word
- `wr_gnt`  out  1  writer word is written to memory this cycle
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after a read
- `lb_we`  out  1  line-buffer write strobe
- `lb_bank`  out  1  target bank; equals parity of the fetched line
- `lb_addr`  out  9  word index within the line
- `lb_wdata`  out  DATA_W  word written to the line buffer
- `fetch_busy`  out  1  a fetch is pending or in progress
- `underrun`  out  1  sticky deadline-miss flag
- `stat_wr_words`  out  32  granted writer words (see Configuration)

## Operation
- **Trigger**
  - Fires in a cycle where `h_count==0`.
  - Next line is `nl = (v_count==V_TOTAL-1) ? 0 : v_count+1`.
  - If `nl < V_ACTIVE`, `fetch_pend` is set at the following edge; otherwise no fetch.
- **Source address**: `nl*LINE_WORDS + i`, for i = 0..LINE_WORDS-1. Implemented as a running line base, not a multiplier.
- **FSM states**: IDLE, FETCH, WRITE.
  - IDLE→FETCH when `fetch_pend`. This has priority over the writer.
  - IDLE→WRITE when `wr_req`.
  - WRITE→FETCH when `fetch_pend`.
  - WRITE→IDLE when `!wr_req`.
  - FETCH→IDLE after the read of word LINE_WORDS-1 is issued. `fetch_pend` clears at the same time.
- **Writer grant**: `wr_gnt = (state==WRITE) && wr_req && !fetch_pend`. When `wr_gnt` is high, `mem_en=mem_we=1` and `mem_addr`/`mem_wdata` carry the writer's address and data. A word is never split.
- **FETCH**: one read per cycle with `mem_we=0`. `lb_we`, `lb_addr` and `lb_wdata=mem_rdata` are registered and delayed 1 cycle from the read.
- **Trigger while a fetch is active or pending**: `underrun` is set and the new trigger is dropped.
- **Deadline**: if `fetch_busy` is high in the cycle `h_count==H_TOTAL-1`, `underrun` is set. The fetch still completes.
- **Reset** (`reset_p` high at an edge):
  - Affected signals: state=IDLE, `fetch_pend`, `wr_gnt`, `mem_en`, `mem_we`, `lb_we`, `fetch_busy`, `underrun`, `stat_wr_words`, all addresses and data.
  - All of them go to 0.
  - A fetch in flight is abandoned, including the delayed `lb_we`.

## Timing
- Trigger at cycle T, then `fetch_pend`=1 and `fetch_busy`=1 from T+1.
- From T+1, `wr_gnt` stays 0.
- FETCH runs T+2..T+321: reads are issued T+2..T+321 and `lb_we` is high T+3..T+322.
- The FSM is in IDLE at T+322. The earliest subsequent writer grant is T+323.
- `fetch_busy` drops at T+322.
- With default parameters, writer bandwidth is at least 1650−323 cycles per active line.

## Configuration
- `FB_ARB_STATS_EN` defined:
  - `stat_wr_words` increments on every `wr_gnt`.
  - It saturates at 0xFFFFFFFF and clears on reset.
- Not defined:
  - `stat_wr_words` is tied to 0.
  - No counter logic is synthesized.

## Structure
- Package `fb_pkg`:
  - typedef enum `fb_arb_state_t` {IDLE, FETCH, WRITE}
  - a function deriving `LINE_WORDS`
  - default timing constants, shared with the timing generator's 1280/1650/720/750 values
- Sub-module `fb_line_addr_gen` holds:
  - the line base register, reset to 0 when `nl==0` and advanced by LINE_WORDS per fetch
  - the word index
  - `lb_bank`

## Test plan
- **Reset**: hold `reset_p` 2 cycles while `wr_req=1` → every output is 0, and `wr_gnt` first rises on the cycle after reset release.
- **Single fetch**: `v_count=5`, `h_count=0` at T, no writer → reads of addresses 1920..2239 at T+2..T+321; `lb_bank=0`; `lb_we` at T+3..T+322 with `lb_addr` 0..319.
- **Wrap and suppression**:
  - `v_count=749` → fetches line 0, addresses 0..319.
  - `v_count=719` and `v_count=730` → no memory reads.
- **Preemption**: `wr_req` held high across T → `wr_gnt` is 1 at T and 0 from T+1 to T+322, returns at T+323; no writer word is lost or duplicated.
- **Underrun**: instantiate with `H_TOTAL=200` → `underrun` rises when `h_count=199` and stays high until reset.
- **Stats**: with `FB_ARB_STATS_EN`, 100 granted writes → `stat_wr_words=100`; without the macro it reads 0.

Source files
------------

// File: rtl/fb_fetch_arbiter_pkg.sv
// Shared types, default video timing and helpers for the frame-buffer fetch arbiter.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } fb_arb_state_t;

    localparam int DEF_H_ACTIVE     = 1280;
    localparam int DEF_H_TOTAL      = 1650;
    localparam int DEF_V_ACTIVE     = 720;
    localparam int DEF_V_TOTAL      = 750;
    localparam int DEF_PIX_PER_WORD = 4;
    localparam int DEF_ADDR_W       = 18;
    localparam int DEF_DATA_W       = 32;
    localparam int LB_ADDR_W        = 9;

    function automatic int line_words(input int h_active, input int pix_per_word);
        return h_active / pix_per_word;
    endfunction

endpackage

// File: rtl/fb_fetch_arbiter_if.sv
// Writer handshake, frame-memory port and line-buffer write port of fb_fetch_arbiter.
interface fb_fetch_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    import fb_pkg::*;

    logic                 wr_req;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_gnt;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 lb_we;
    logic                 lb_bank;
    logic [LB_ADDR_W-1:0] lb_addr;
    logic [DATA_W-1:0]    lb_wdata;

    modport master (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_gnt, mem_en, mem_we, mem_addr, mem_wdata,
        output lb_we, lb_bank, lb_addr, lb_wdata
    );

    modport slave (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_gnt, mem_en, mem_we, mem_addr, mem_wdata,
        input  lb_we, lb_bank, lb_addr, lb_wdata
    );

endinterface

// File: rtl/fb_line_addr_gen.sv
// Running line base, word index and ping-pong bank select for the display line prefetch.
module fb_line_addr_gen
    import fb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_WORDS = DEF_H_ACTIVE / DEF_PIX_PER_WORD
) (
    input  logic                 rfr_clk,
    input  logic                 reset_p,
    input  logic                 start,
    input  logic                 first_line,
    input  logic                 line_lsb,
    input  logic                 advance,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [LB_ADDR_W-1:0] word_idx,
    output logic                 last_word,
    output logic                 lb_bank
);

    logic [ADDR_W-1:0] line_base;

    // The base tracks lines in fetch order, so it restarts at line 0 instead of multiplying.
    always_ff @(posedge rfr_clk) begin
        if (reset_p) begin
            line_base <= '0;
            word_idx  <= '0;
            lb_bank   <= 1'b0;
        end else begin
            if (start) begin
                line_base <= first_line ? '0 : line_base + ADDR_W'(LINE_WORDS);
                lb_bank   <= line_lsb;
            end
            if (advance) begin
                word_idx <= last_word ? '0 : word_idx + LB_ADDR_W'(1);
            end
        end
    end

    assign last_word = (word_idx == LB_ADDR_W'(LINE_WORDS - 1));
    assign rd_addr   = line_base + ADDR_W'(word_idx);

endmodule

// File: rtl/fb_fetch_arbiter.sv
// Frame-memory scheduler: line prefetch preempts the pixel writer at word boundaries.
// Define FB_ARB_STATS_EN to build the saturating granted-writer-word counter.
module fb_fetch_arbiter
    import fb_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic               rfr_clk,
    input  logic               reset_p,
    input  logic [11:0]        h_count,
    input  logic [11:0]        v_count,
    fb_fetch_arbiter_if.master bus,
    output logic               fetch_busy,
    output logic               underrun,
    output logic [31:0]        stat_wr_words
);

    localparam int LINE_WORDS = line_words(H_ACTIVE, PIX_PER_WORD);

    fb_arb_state_t        state;
    fb_arb_state_t        state_next;
    logic                 fetch_pend;
    logic                 gnt;
    logic                 trig;
    logic                 start;
    logic                 last_word;
    logic [11:0]          next_line;
    logic [ADDR_W-1:0]    rd_addr;
    logic [LB_ADDR_W-1:0] word_idx;

    assign next_line  = (v_count == 12'(V_TOTAL - 1)) ? 12'd0 : v_count + 12'd1;
    assign trig       = (h_count == 12'd0) && (next_line < 12'(V_ACTIVE));
    assign start      = trig && !fetch_pend;
    assign fetch_busy = fetch_pend;

    fb_line_addr_gen #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_addr_gen (
        .rfr_clk    (rfr_clk),
        .reset_p    (reset_p),
        .start      (start),
        .first_line (next_line == 12'd0),
        .line_lsb   (next_line[0]),
        .advance    (state == FETCH),
        .rd_addr    (rd_addr),
        .word_idx   (word_idx),
        .last_word  (last_word),
        .lb_bank    (bus.lb_bank)
    );

    always_ff @(posedge rfr_clk) begin
        if (reset_p) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fetch_pend) begin
                    state_next = FETCH;
                end else if (bus.wr_req) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (fetch_pend) begin
                    state_next = FETCH;
                end else if (!bus.wr_req) begin
                    state_next = IDLE;
                end
            end
            FETCH: begin
                if (last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pending fetch masks the grant immediately, so the writer loses the port on a word boundary.
    always_comb begin
        gnt           = (state == WRITE) && bus.wr_req && !fetch_pend;
        bus.wr_gnt    = gnt;
        bus.mem_en    = gnt || (state == FETCH);
        bus.mem_we    = gnt;
        bus.mem_addr  = ADDR_W'(0);
        bus.mem_wdata = DATA_W'(0);
        if (gnt) begin
            bus.mem_addr  = bus.wr_addr;
            bus.mem_wdata = bus.wr_data;
        end else if (state == FETCH) begin
            bus.mem_addr = rd_addr;
        end
        bus.lb_wdata = bus.lb_we ? bus.mem_rdata : DATA_W'(0);
    end

    // Read data returns one cycle after the read, so the line-buffer strobe and index trail by one.
    always_ff @(posedge rfr_clk) begin
        if (reset_p) begin
            fetch_pend  <= 1'b0;
            underrun    <= 1'b0;
            bus.lb_we   <= 1'b0;
            bus.lb_addr <= '0;
        end else begin
            if (start) begin
                fetch_pend <= 1'b1;
            end else if ((state == FETCH) && last_word) begin
                fetch_pend <= 1'b0;
            end
            if (fetch_pend && (trig || (h_count == 12'(H_TOTAL - 1)))) begin
                underrun <= 1'b1;
            end
            bus.lb_we   <= (state == FETCH);
            bus.lb_addr <= word_idx;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_count;

    always_ff @(posedge rfr_clk) begin
        if (reset_p) begin
            stat_count <= '0;
        end else if (gnt && (stat_count != 32'hFFFF_FFFF)) begin
            stat_count <= stat_count + 32'd1;
        end
    end

    assign stat_wr_words = stat_count;
`else
    assign stat_wr_words = 32'd0;
`endif

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Scoreboard bench for fb_fetch_arbiter: default instance plus a short-line (H_TOTAL=200) instance.
module tb_fb_fetch_arbiter;

    localparam int LW = 320;

    typedef struct {
        int          cyc;
        logic [17:0] addr;
    } rd_exp_t;

    typedef struct {
        int          cyc;
        logic [8:0]  idx;
        logic        bank;
        logic [31:0] data;
    } lb_exp_t;

    typedef struct {
        logic [17:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    logic        rfr_clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [11:0] h_count = 12'd100;
    logic [11:0] v_count = 12'd0;
    logic [11:0] h_s     = 12'd5;
    logic [11:0] v_s     = 12'd0;
    logic        fetch_busy, underrun, s_busy, s_underrun;
    logic [31:0] stat, s_stat;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    rd_exp_t rd_q[$];
    lb_exp_t lb_q[$];
    wr_exp_t wr_q[$];

    fb_fetch_arbiter_if #(.ADDR_W(18), .DATA_W(32)) bus ();
    fb_fetch_arbiter_if #(.ADDR_W(18), .DATA_W(32)) sbus ();

    fb_fetch_arbiter u_dut (
        .rfr_clk       (rfr_clk),
        .reset_p       (reset_p),
        .h_count       (h_count),
        .v_count       (v_count),
        .bus           (bus),
        .fetch_busy    (fetch_busy),
        .underrun      (underrun),
        .stat_wr_words (stat)
    );

    fb_fetch_arbiter #(.H_TOTAL(200)) u_short (
        .rfr_clk       (rfr_clk),
        .reset_p       (reset_p),
        .h_count       (h_s),
        .v_count       (v_s),
        .bus           (sbus),
        .fetch_busy    (s_busy),
        .underrun      (s_underrun),
        .stat_wr_words (s_stat)
    );

    always #5 rfr_clk = ~rfr_clk;

    always @(posedge rfr_clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return {a[13:0], a} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rfr_clk);
        #1;
    endtask

    task automatic trigger(input logic [11:0] v);
        v_count = v;
        h_count = 12'd0;
        tick(1);
        h_count = 12'd100;
    endtask

    task automatic expect_fetch(input int t, input int line);
        rd_exp_t     r;
        lb_exp_t     l;
        logic [17:0] a;
        for (int i = 0; i < LW; i++) begin
            a      = 18'(line * LW + i);
            r.cyc  = t + 2 + i;
            r.addr = a;
            rd_q.push_back(r);
            l.cyc  = t + 3 + i;
            l.idx  = 9'(i);
            l.bank = line[0];
            l.data = mem_word(a);
            lb_q.push_back(l);
        end
    endtask

    task automatic send_words(input int n, input logic [17:0] a0, input logic [31:0] d0);
        wr_exp_t w;
        int      guard;
        for (int i = 0; i < n; i++) begin
            w.addr = a0 + 18'(i);
            w.data = d0 + 32'(i);
            wr_q.push_back(w);
            bus.wr_req  = 1'b1;
            bus.wr_addr = w.addr;
            bus.wr_data = w.data;
            guard = 0;
            do begin
                @(negedge rfr_clk);
                guard++;
            end while (!bus.wr_gnt && guard < 1000);
            chk("writer_grant_timeout", 64'(guard >= 1000), 64'd0);
            @(posedge rfr_clk);
            #1;
        end
        bus.wr_req = 1'b0;
    endtask

    // Frame memory: read data is valid only in the cycle after the read, garbage otherwise.
    initial begin : mem_model
        logic        p;
        logic [17:0] a;
        bus.mem_rdata  = 32'h0;
        sbus.mem_rdata = 32'h0;
        forever begin
            @(negedge rfr_clk);
            p = bus.mem_en && !bus.mem_we;
            a = bus.mem_addr;
            @(posedge rfr_clk);
            #1;
            bus.mem_rdata = p ? mem_word(a) : 32'hDEAD_BEEF;
        end
    end

    // Scoreboard monitor: every read, line-buffer write and writer grant pops one expectation.
    always @(negedge rfr_clk) begin : monitor
        rd_exp_t r;
        lb_exp_t l;
        wr_exp_t w;
        if (!reset_p) begin
            if (bus.mem_en && !bus.mem_we) begin
                chk("read_expected", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0) begin
                    r = rd_q.pop_front();
                    chk("read_cycle", 64'(cyc), 64'(r.cyc));
                    chk("read_addr", 64'(bus.mem_addr), 64'(r.addr));
                end
            end
            if (bus.lb_we) begin
                chk("lb_expected", 64'(lb_q.size() != 0), 64'd1);
                if (lb_q.size() != 0) begin
                    l = lb_q.pop_front();
                    chk("lb_cycle", 64'(cyc), 64'(l.cyc));
                    chk("lb_addr", 64'(bus.lb_addr), 64'(l.idx));
                    chk("lb_bank", 64'(bus.lb_bank), 64'(l.bank));
                    chk("lb_wdata", 64'(bus.lb_wdata), 64'(l.data));
                end
            end
            if (bus.mem_en && bus.mem_we) begin
                chk("write_has_grant", 64'(bus.wr_gnt), 64'd1);
            end
            if (bus.wr_gnt) begin
                chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    chk("wr_mem_we", 64'(bus.mem_en && bus.mem_we), 64'd1);
                    chk("wr_mem_addr", 64'(bus.mem_addr), 64'(w.addr));
                    chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'(w.data));
                end
            end
        end
    end

    // Free-running short line counter for the H_TOTAL=200 instance.
    initial begin : short_counter
        forever begin
            @(posedge rfr_clk);
            #1;
            if (reset_p) h_s = 12'd5;
            else         h_s = (h_s == 12'd199) ? 12'd0 : h_s + 12'd1;
        end
    end

    initial begin : short_check
        int   guard;
        logic seen;
        wait (reset_p == 1'b0);
        guard = 0;
        while (h_s != 12'd0 && guard < 1000) begin
            @(posedge rfr_clk);
            #2;
            guard++;
        end
        chk("short_trigger_timeout", 64'(guard >= 1000), 64'd0);
        seen = 1'b0;
        repeat (199) begin
            @(posedge rfr_clk);
            #2;
            if (s_underrun) seen = 1'b1;
        end
        chk("short_underrun_early", 64'(seen), 64'd0);
        chk("short_busy_at_deadline", 64'(s_busy), 64'd1);
        @(posedge rfr_clk);
        #2;
        chk("short_underrun_set", 64'(s_underrun), 64'd1);
        repeat (250) @(posedge rfr_clk);
        #2;
        chk("short_underrun_sticky", 64'(s_underrun), 64'd1);
    end

    initial begin : stimulus
        int      t;
        logic    blocked;
        wr_exp_t w;
        sbus.wr_req  = 1'b0;
        sbus.wr_addr = 18'd0;
        sbus.wr_data = 32'd0;
        bus.wr_req   = 1'b1;
        bus.wr_addr  = 18'h01234;
        bus.wr_data  = 32'hAAAA_5555;
        w.addr = 18'h01234;
        w.data = 32'hAAAA_5555;
        wr_q.push_back(w);

        tick(2);
        chk("reset_ctrl", 64'({bus.wr_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.lb_we,
                               bus.lb_bank, bus.lb_addr, fetch_busy, underrun}), 64'd0);
        chk("reset_data", {bus.mem_wdata, bus.lb_wdata}, 64'd0);
        chk("reset_stat", 64'(stat), 64'd0);
        reset_p = 1'b0;
        chk("gnt_in_release_cycle", 64'(bus.wr_gnt), 64'd0);
        tick(1);
        chk("gnt_after_release", 64'(bus.wr_gnt), 64'd1);
        tick(1);
        bus.wr_req = 1'b0;
        tick(5);

        $display("[TB] wrap fetch of line 0");
        t = cyc;
        expect_fetch(t, 0);
        trigger(12'd749);
        chk("busy_after_trigger", 64'(fetch_busy), 64'd1);
        tick(320);
        chk("busy_last_read", 64'(fetch_busy), 64'd1);
        tick(1);
        chk("busy_dropped", 64'(fetch_busy), 64'd0);
        tick(8);

        $display("[TB] line fetches 1..6");
        for (int v = 0; v <= 5; v++) begin
            t = cyc;
            expect_fetch(t, v + 1);
            trigger(12'(v));
            tick(330);
        end

        $display("[TB] suppressed triggers");
        trigger(12'd719);
        chk("no_fetch_v719", 64'(fetch_busy), 64'd0);
        tick(330);
        trigger(12'd730);
        chk("no_fetch_v730", 64'(fetch_busy), 64'd0);
        tick(330);

        $display("[TB] writer preemption");
        fork
            send_words(20, 18'h03000, 32'hC0DE_0000);
        join_none
        tick(10);
        chk("gnt_at_trigger", 64'(bus.wr_gnt), 64'd1);
        t = cyc;
        expect_fetch(t, 7);
        trigger(12'd6);
        blocked = 1'b0;
        for (int i = 0; i < 322; i++) begin
            if (bus.wr_gnt) blocked = 1'b1;
            tick(1);
        end
        chk("gnt_blocked_by_fetch", 64'(blocked), 64'd0);
        chk("gnt_resumes", 64'(bus.wr_gnt), 64'd1);
        tick(20);

        $display("[TB] overlapping trigger");
        t = cyc;
        expect_fetch(t, 8);
        trigger(12'd7);
        tick(4);
        chk("underrun_before_overlap", 64'(underrun), 64'd0);
        trigger(12'd7);
        chk("underrun_on_overlap", 64'(underrun), 64'd1);
        tick(330);
        chk("underrun_sticky", 64'(underrun), 64'd1);

        $display("[TB] reset during fetch");
        t = cyc;
        expect_fetch(t, 9);
        trigger(12'd8);
        tick(48);
        reset_p = 1'b1;
        rd_q.delete();
        lb_q.delete();
        tick(2);
        reset_p = 1'b0;
        chk("underrun_cleared", 64'(underrun), 64'd0);
        chk("busy_cleared", 64'(fetch_busy), 64'd0);
        chk("short_underrun_cleared", 64'(s_underrun), 64'd0);
        tick(30);

        $display("[TB] writer statistics");
        send_words(100, 18'h05000, 32'h1000_0000);
        tick(2);
`ifdef FB_ARB_STATS_EN
        chk("stat_wr_words", 64'(stat), 64'd100);
`else
        chk("stat_wr_words", 64'(stat), 64'd0);
`endif

        chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        chk("lb_queue_drained", 64'(lb_q.size()), 64'd0);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
